metropolis_bank: RTL and testbench
==================================

Name: metropolis_bank

Overview:
- Parametrised successor to the single-replica distance accumulator.
- Holds the total tour distance for NREP replicas and applies a Metropolis accept/reject test to each proposed move.
- Accumulates accepted deltas with saturation and keeps per-replica acceptance counters.
- Executes neighbour exchange (swap) and load commands through a drain/execute state machine. Sits between the per-replica delta calculators and the exchange controller.

Parameters:
NREP, 8, number of replicas (>=2)
RW, $clog2(NREP), replica index width
DW, 27, unsigned total-distance width
DDW, 24, signed delta/threshold width
CW, 16, acceptance counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  move proposal valid
in_ready  out  1  move proposal accepted when in_valid & in_ready
in_rep  in  RW  target replica
in_delta  in  DDW  signed distance change of the move
in_thresh  in  DDW  signed acceptance threshold (precomputed -T*ln(rand))
in_thr_only  in  1  decide only, never update total (threshold-probe mode)
acc_valid  out  1  decision result valid, single-cycle pulse
acc_rep  out  RW  replica of the decision
acc_flag  out  1  1 = move accepted
cmd_valid  in  1  command valid
cmd_ready  out  1  command completes in the cycle of cmd_valid & cmd_ready
cmd_op  in  1  0 = SWAP(idx, idx+1), 1 = LOAD(idx)
cmd_idx  in  RW  command replica index
cmd_data  in  DW  LOAD value
cnt_clr  in  1  synchronous clear of all acceptance counters
rd_rep  in  RW  read index
rd_total  out  DW  bank[rd_rep], registered
rd_cnt  out  CW  counter[rd_rep], registered

Behaviour:
- Reset (async):
  - all totals, counters, rd_total, rd_cnt, acc_valid, acc_rep and acc_flag go to 0.
  - state goes to RUN; pipeline valids clear.
  - Reset mid-operation discards in-flight moves and any pending command.
- Pipeline, two stages:
  - Stage A registers rep, delta, thresh and thr_only, plus bank[rep]. It forwards the stage-B result when stage B writes the same replica in that cycle.
  - Stage B decides: accept = (delta <= thresh), signed compare.
  - If accept & !thr_only: bank[rep] <= sat(bank + sext(delta)).
    - sat clamps a negative result to 0 and a result above 2^DW-1 to 2^DW-1.
  - If accept: counter[rep] increments, saturating at 2^CW-1. It increments even when thr_only is set.
  - acc_valid/acc_rep/acc_flag are registered from stage B. Latency: a handshake in cycle t gives acc_valid in cycle t+2.
- Back-to-back moves to the same replica must each see the previous result (forwarding); throughput is 1 move/cycle.
- in_ready = (state==RUN) & !cmd_valid. A command therefore blocks new moves combinationally.
- FSM:
  - RUN: cmd_valid -> DRAIN.
  - DRAIN: when stage A and stage B are both empty -> EXEC.
  - EXEC: cmd_ready=1 for one cycle.
    - SWAP exchanges bank[idx] and bank[idx+1]. Counters are not swapped; they belong to the temperature slot.
    - SWAP with idx >= NREP-1 is a no-op but still handshakes.
    - LOAD writes bank[idx] <= cmd_data.
    - Next state is RUN.
  - cmd_ready is 0 in RUN and DRAIN. Minimum command latency: the cmd_valid cycle, then drain cycles, then the EXEC cycle.
- cnt_clr zeroes all counters at the next edge. It has priority over a same-cycle increment. It is honoured in any state.
- Read port: rd_total and rd_cnt at cycle t+1 reflect rd_rep sampled at t and all writes committed by the edge ending t.
- in_rep >= NREP: the move flows through, acc_flag is reported, and no state is modified.

Test Plan:
- LOAD idx 2 with 1000, then move rep2 delta -50 thresh 0 -> acc_flag=1 at t+2; rd_total[2]=950; rd_cnt[2]=1.
- Move rep2 delta +30 thresh +10 -> acc_flag=0; total stays 950; counter stays 1. Repeat with in_thr_only=1, delta -5, thresh 0 -> accepted, total 950, counter 2.
- Four back-to-back moves on rep5 (loaded 100), each delta -10 thresh 0 -> totals 90, 80, 70, 60 without bubbles; in_ready stays 1.
- Saturation:
  - rep0=20 with delta -100 accepted -> total 0.
  - rep1=2^27-10 with delta +100 -> 2^27-1.
  - counter preset near max: after 2^16+3 accepts it stays at 65535.
- Move in flight on rep3 while SWAP idx 3 is asserted -> in_ready drops that cycle; the swap executes only after the move commits; bank[3] and bank[4] swapped including the move's result; cmd_ready a single pulse. SWAP idx 7 (NREP=8) -> nothing changes, handshake completes.
- Assert reset during DRAIN with two moves in flight -> all outputs 0, state RUN; no acc_valid pulse afterwards; cnt_clr together with an accept -> counter 0.

Source files
------------

// File: rtl/metropolis_bank.sv
// Multi-replica tour-distance bank with a two-stage Metropolis accept/reject pipeline,
// saturating totals and acceptance counters, and drained SWAP/LOAD command execution.
module metropolis_bank #(
    parameter int unsigned NREP = 8,
    parameter int unsigned RW   = $clog2(NREP),
    parameter int unsigned DW   = 27,
    parameter int unsigned DDW  = 24,
    parameter int unsigned CW   = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [RW-1:0]  in_rep,
    input  logic [DDW-1:0] in_delta,
    input  logic [DDW-1:0] in_thresh,
    input  logic           in_thr_only,
    output logic           acc_valid,
    output logic [RW-1:0]  acc_rep,
    output logic           acc_flag,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_op,
    input  logic [RW-1:0]  cmd_idx,
    input  logic [DW-1:0]  cmd_data,
    input  logic           cnt_clr,
    input  logic [RW-1:0]  rd_rep,
    output logic [DW-1:0]  rd_total,
    output logic [CW-1:0]  rd_cnt
);

    typedef enum logic [1:0] {StRun, StDrain, StExec} state_e;

    localparam int unsigned SW = DW + 2;
    localparam logic [DW-1:0] TotMax = '1;
    localparam logic [CW-1:0] CntMax = '1;

    state_e state_q, state_d;

    logic           a_valid_q, a_valid_d;
    logic [RW-1:0]  a_rep_q, a_rep_d;
    logic [DDW-1:0] a_delta_q, a_delta_d;
    logic [DDW-1:0] a_thresh_q, a_thresh_d;
    logic           a_thr_only_q, a_thr_only_d;
    logic [DW-1:0]  a_total_q, a_total_d;

    logic [DW-1:0]  bank_q [NREP];
    logic [DW-1:0]  bank_d [NREP];
    logic [CW-1:0]  cnt_q [NREP];
    logic [CW-1:0]  cnt_d [NREP];

    logic           acc_valid_q, acc_valid_d;
    logic [RW-1:0]  acc_rep_q, acc_rep_d;
    logic           acc_flag_q, acc_flag_d;
    logic [DW-1:0]  rd_total_q, rd_total_d;
    logic [CW-1:0]  rd_cnt_q, rd_cnt_d;

    logic           in_fire, cmd_fire, swap_ok;
    logic           b_ok, b_accept, b_wr, b_inc;
    logic signed [SW-1:0] b_sum;
    logic [DW-1:0]  b_new;
    logic [DW-1:0]  in_total;

    // Stage B: decision and saturating update on the stage-A registers
    always_comb begin
        b_ok     = 32'(a_rep_q) < NREP;
        b_accept = $signed(a_delta_q) <= $signed(a_thresh_q);
        b_sum    = $signed({2'b00, a_total_q})
                 + $signed({{(SW-DDW){a_delta_q[DDW-1]}}, a_delta_q});
        if (b_sum[SW-1]) begin
            b_new = '0;
        end else if (b_sum[SW-2]) begin
            b_new = TotMax;
        end else begin
            b_new = b_sum[DW-1:0];
        end
        b_wr  = a_valid_q & b_accept & ~a_thr_only_q & b_ok;
        b_inc = a_valid_q & b_accept & b_ok;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        cmd_ready = 1'b0;
        unique case (state_q)
            StRun: begin
                in_ready = ~cmd_valid;
                if (cmd_valid) state_d = StDrain;
            end
            StDrain: begin
                if (!a_valid_q && !acc_valid_q) state_d = StExec;
            end
            StExec: begin
                cmd_ready = 1'b1;
                state_d   = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // Stage A: capture the move and its current total, forwarding a same-cycle stage-B write
    always_comb begin
        in_fire  = in_valid & in_ready;
        in_total = '0;
        for (int unsigned i = 0; i < NREP; i++) begin
            if (32'(in_rep) == i) in_total = bank_q[RW'(i)];
        end
        if (b_wr && a_rep_q == in_rep) in_total = b_new;

        a_valid_d    = in_fire;
        a_rep_d      = a_rep_q;
        a_delta_d    = a_delta_q;
        a_thresh_d   = a_thresh_q;
        a_thr_only_d = a_thr_only_q;
        a_total_d    = a_total_q;
        if (in_fire) begin
            a_rep_d      = in_rep;
            a_delta_d    = in_delta;
            a_thresh_d   = in_thresh;
            a_thr_only_d = in_thr_only;
            a_total_d    = in_total;
        end
    end

    // Commands only execute once the pipeline is empty, so they never collide with b_wr
    always_comb begin
        cmd_fire = cmd_valid & cmd_ready;
        swap_ok  = 32'(cmd_idx) < NREP - 1;
        for (int unsigned i = 0; i < NREP; i++) begin
            bank_d[RW'(i)] = bank_q[RW'(i)];
            if (b_wr && 32'(a_rep_q) == i) bank_d[RW'(i)] = b_new;
            if (cmd_fire && cmd_op && 32'(cmd_idx) == i) bank_d[RW'(i)] = cmd_data;
            if (cmd_fire && !cmd_op && swap_ok) begin
                if (32'(cmd_idx) == i) bank_d[RW'(i)] = bank_q[RW'((i + 1) % NREP)];
                if (32'(cmd_idx) + 1 == i) bank_d[RW'(i)] = bank_q[RW'((i + NREP - 1) % NREP)];
            end

            cnt_d[RW'(i)] = cnt_q[RW'(i)];
            if (cnt_clr) begin
                cnt_d[RW'(i)] = '0;
            end else if (b_inc && 32'(a_rep_q) == i && cnt_q[RW'(i)] != CntMax) begin
                cnt_d[RW'(i)] = cnt_q[RW'(i)] + 1'b1;
            end
        end
    end

    always_comb begin
        acc_valid_d = a_valid_q;
        acc_rep_d   = a_valid_q ? a_rep_q : acc_rep_q;
        acc_flag_d  = a_valid_q & b_accept;

        // Read port sees everything committed at the coming edge
        rd_total_d = '0;
        rd_cnt_d   = '0;
        for (int unsigned i = 0; i < NREP; i++) begin
            if (32'(rd_rep) == i) begin
                rd_total_d = bank_d[RW'(i)];
                rd_cnt_d   = cnt_d[RW'(i)];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StRun;
            a_valid_q    <= 1'b0;
            a_rep_q      <= '0;
            a_delta_q    <= '0;
            a_thresh_q   <= '0;
            a_thr_only_q <= 1'b0;
            a_total_q    <= '0;
            bank_q       <= '{default: '0};
            cnt_q        <= '{default: '0};
            acc_valid_q  <= 1'b0;
            acc_rep_q    <= '0;
            acc_flag_q   <= 1'b0;
            rd_total_q   <= '0;
            rd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            a_valid_q    <= a_valid_d;
            a_rep_q      <= a_rep_d;
            a_delta_q    <= a_delta_d;
            a_thresh_q   <= a_thresh_d;
            a_thr_only_q <= a_thr_only_d;
            a_total_q    <= a_total_d;
            bank_q       <= bank_d;
            cnt_q        <= cnt_d;
            acc_valid_q  <= acc_valid_d;
            acc_rep_q    <= acc_rep_d;
            acc_flag_q   <= acc_flag_d;
            rd_total_q   <= rd_total_d;
            rd_cnt_q     <= rd_cnt_d;
        end
    end

    assign acc_valid = acc_valid_q;
    assign acc_rep   = acc_rep_q;
    assign acc_flag  = acc_flag_q;
    assign rd_total  = rd_total_q;
    assign rd_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_metropolis_bank.sv
// Scoreboard bench for metropolis_bank: decisions are queued at handshake and
// popped when acc_valid fires; totals and counters are checked via the read port.
module tb_metropolis_bank;

    localparam int RW  = 3;
    localparam int DW  = 27;
    localparam int DDW = 24;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, in_ready, in_thr_only;
    logic [RW-1:0]  in_rep;
    logic [DDW-1:0] in_delta, in_thresh;
    logic           acc_valid, acc_flag;
    logic [RW-1:0]  acc_rep;
    logic           cmd_valid, cmd_ready, cmd_op;
    logic [RW-1:0]  cmd_idx;
    logic [DW-1:0]  cmd_data;
    logic           cnt_clr;
    logic [RW-1:0]  rd_rep;
    logic [DW-1:0]  rd_total;
    logic [CW-1:0]  rd_cnt;

    metropolis_bank dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rep     (in_rep),
        .in_delta   (in_delta),
        .in_thresh  (in_thresh),
        .in_thr_only(in_thr_only),
        .acc_valid  (acc_valid),
        .acc_rep    (acc_rep),
        .acc_flag   (acc_flag),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_idx    (cmd_idx),
        .cmd_data   (cmd_data),
        .cnt_clr    (cnt_clr),
        .rd_rep     (rd_rep),
        .rd_total   (rd_total),
        .rd_cnt     (rd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     rep;
        int     flag;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   sb_e;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    int     stalls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && acc_valid) begin
            if (sb.size() == 0) begin
                check_eq("acc_spurious", 32'(acc_valid), 0);
            end else begin
                sb_e = sb.pop_front();
                check_eq("acc_rep", 32'(acc_rep), sb_e.rep);
                check_eq("acc_flag", 32'(acc_flag), sb_e.flag);
                check_eq("acc_latency", 32'(cyc), 32'(sb_e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the handshake edge
    task automatic do_move(input int rep, input int delta, input int thresh, input bit thr);
        bit done = 0;
        in_valid    = 1'b1;
        in_rep      = RW'(rep);
        in_delta    = DDW'(delta);
        in_thresh   = DDW'(thresh);
        in_thr_only = thr;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (in_ready) begin
                done = 1;
                sb.push_back('{rep, (delta <= thresh) ? 1 : 0, cyc + 2});
            end else begin
                stalls++;
            end
            @(negedge clk);
        end
        in_valid    = 1'b0;
        in_thr_only = 1'b0;
        if (!done) check_eq("move_handshake", 0, 1);
    endtask

    task automatic do_cmd(input bit op, input int idx, input int data);
        bit done = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = RW'(idx);
        cmd_data  = DW'(data);
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (k == 0) check_eq("cmd_blocks_in_ready", 32'(in_ready), 0);
            if (cmd_ready) done = 1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check_eq("cmd_handshake", 32'(done), 1);
        #1;
        check_eq("cmd_ready_pulse", 32'(cmd_ready), 0);
        @(negedge clk);
    endtask

    task automatic rd_chk(input int rep, input int exp_tot, input int exp_cnt);
        rd_rep = RW'(rep);
        @(negedge clk);
        check_eq($sformatf("rd_total[%0d]", rep), 32'(rd_total), exp_tot);
        check_eq($sformatf("rd_cnt[%0d]", rep), 32'(rd_cnt), exp_cnt);
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_rep      = '0;
        in_delta    = '0;
        in_thresh   = '0;
        in_thr_only = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 1'b0;
        cmd_idx     = '0;
        cmd_data    = '0;
        cnt_clr     = 1'b0;
        rd_rep      = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_acc_valid", 32'(acc_valid), 0);
        check_eq("rst_acc_rep", 32'(acc_rep), 0);
        check_eq("rst_acc_flag", 32'(acc_flag), 0);
        check_eq("rst_rd_total", 32'(rd_total), 0);
        check_eq("rst_rd_cnt", 32'(rd_cnt), 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("run_in_ready", 32'(in_ready), 1);

        // Basic accept / reject / threshold probe on replica 2
        do_cmd(1'b1, 2, 1000);
        rd_chk(2, 1000, 0);
        do_move(2, -50, 0, 1'b0);
        rd_chk(2, 950, 1);
        do_move(2, 30, 10, 1'b0);
        rd_chk(2, 950, 1);
        do_move(2, -5, 0, 1'b1);
        rd_chk(2, 950, 2);

        // Back-to-back moves on one replica exercise forwarding
        do_cmd(1'b1, 5, 100);
        rd_rep = 3'd5;
        stalls = 0;
        for (int k = 0; k < 4; k++) begin
            do_move(5, -10, 0, 1'b0);
            if (k > 0) check_eq($sformatf("b2b_total_%0d", k), 32'(rd_total), 100 - 10 * k);
        end
        @(negedge clk);
        check_eq("b2b_total_final", 32'(rd_total), 60);
        check_eq("b2b_stalls", stalls, 0);

        // Saturation at both ends of the total range
        do_cmd(1'b1, 0, 20);
        do_move(0, -100, 0, 1'b0);
        rd_chk(0, 0, 1);
        do_cmd(1'b1, 1, (1 << 27) - 10);
        do_move(1, 100, 100, 1'b0);
        rd_chk(1, (1 << 27) - 1, 1);

        // Counter saturation
        for (int k = 0; k < 65539; k++) do_move(6, 0, 0, 1'b1);
        rd_chk(6, 0, 65535);

        // SWAP behind an in-flight move
        do_cmd(1'b1, 3, 500);
        do_cmd(1'b1, 4, 700);
        do_move(3, -20, 0, 1'b0);
        do_cmd(1'b0, 3, 0);
        rd_chk(3, 700, 1);
        rd_chk(4, 480, 0);

        // SWAP at the last index must not wrap
        do_cmd(1'b1, 7, 1234);
        do_cmd(1'b0, 7, 0);
        rd_chk(7, 1234, 0);
        rd_chk(0, 0, 1);

        // Reset while a command is draining
        do_move(2, -1, 0, 1'b0);
        do_move(2, -1, 0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 1'b1;
        cmd_idx   = 3'd5;
        cmd_data  = 27'd5;
        rd_rep    = 3'd2;
        @(posedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check_eq("mid_rst_acc_valid", 32'(acc_valid), 0);
        check_eq("mid_rst_acc_flag", 32'(acc_flag), 0);
        check_eq("mid_rst_acc_rep", 32'(acc_rep), 0);
        check_eq("mid_rst_rd_total", 32'(rd_total), 0);
        check_eq("mid_rst_rd_cnt", 32'(rd_cnt), 0);
        check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        repeat (4) @(negedge clk);
        rd_chk(5, 0, 0);
        rd_chk(2, 0, 0);

        // cnt_clr wins over a same-cycle increment
        do_move(1, -1, 0, 1'b0);
        rd_chk(1, 0, 1);
        do_move(0, -1, 0, 1'b0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        rd_chk(0, 0, 0);
        rd_chk(1, 0, 0);

        repeat (4) @(negedge clk);
        check_eq("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
